// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiply, restoring divide.
// Define MD_FAST_MULT_EN to replace the iterative multiply with a single-cycle array product.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mdOp,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;       // {partial product hi, multiplier} or {rem, quo}
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               is_div_q, is_div_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               s1, s2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   fix_quo, fix_rem;

    // Odd opcodes (multu/divu) are unsigned
    assign s1   = ~mdOp[0] & din1[WIDTH-1];
    assign s2   = ~mdOp[0] & din2[WIDTH-1];
    assign mag1 = s1 ? (~din1 + 1'b1) : din1;
    assign mag2 = s2 ? (~din2 + 1'b1) : din2;

    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mcand_q};
    assign div_diff  = div_shift - {1'b0, mcand_q};

    assign fix_prod = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    assign fix_quo  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign fix_rem  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (mdOp)
                        3'b000, 3'b001: begin
                            neg_res_d = s1 ^ s2;
                            neg_rem_d = 1'b0;
                            is_div_d  = 1'b0;
                            dz_d      = 1'b0;
                            mcand_d   = mag1;
                            cnt_d     = '0;
                            busy_d    = 1'b1;
`ifdef MD_FAST_MULT_EN
                            acc_d     = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
                            state_d   = StFix;
`else
                            acc_d     = {{WIDTH{1'b0}}, mag2};
                            state_d   = StMul;
`endif
                        end
                        3'b010, 3'b011: begin
                            neg_res_d = s1 ^ s2;
                            neg_rem_d = s1;
                            is_div_d  = 1'b1;
                            dz_d      = (din2 == '0);
                            mcand_d   = mag2;
                            acc_d     = {{WIDTH{1'b0}}, mag1};
                            cnt_d     = '0;
                            busy_d    = 1'b1;
                            state_d   = StDiv;
                        end
                        3'b100: begin
                            hi_d   = din1;
                            done_d = 1'b1;
                        end
                        3'b101: begin
                            lo_d   = din1;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            StMul: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
            end
            StDiv: begin
                // A zero divisor never fails the compare, so the dividend shifts into rem
                acc_d = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                               : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
            end
            StFix: begin
                if (is_div_q) begin
                    hi_d = fix_rem;
                    lo_d = dz_q ? '1 : fix_quo;
                end else begin
                    {hi_d, lo_d} = fix_prod;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Flush overrides everything, including a same-cycle start
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected HI/LO, a monitor
// pops and compares on every done pulse.
module tb_mult_div_unit;

    localparam int unsigned W = 32;
`ifdef MD_FAST_MULT_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = 33;
`endif
    localparam int DivLat = 33;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   mdOp = 3'b110;
    logic [W-1:0] din1 = '0;
    logic [W-1:0] din2 = '0;
    logic         flush = 1'b0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mdOp  (mdOp),
        .din1  (din1),
        .din2  (din2),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done got hi=%h lo=%h, none expected", hi, lo);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (hi !== e.hi || lo !== e.lo) begin
                    failures++;
                    $display("FAIL result got hi=%h lo=%h exp hi=%h lo=%h", hi, lo, e.hi, e.lo);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] h, input logic [W-1:0] l);
        exp_t e;
        e.hi = h;
        e.lo = l;
        m_hi = h;
        m_lo = l;
        sb.push_back(e);
    endtask

    task automatic pulse_start(input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        mdOp  = op;
        din1  = a;
        din2  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        mdOp  = 3'b110;
    endtask

    // Issue one op, measure how many sampled cycles busy stays high, then let done pass
    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int lat);
        int n;
        n = 0;
        pulse_start(op, a, b);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk({name, "_latency"}, n, lat);
        @(negedge clk);
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_busy", busy, '0);
        chk("rst_done", done, '0);
        @(negedge clk);
        rst_n = 1'b1;

        push(32'h0000_0000, 32'h0000_000F);
        run_op("mult_5x3", 3'b000, 32'd5, 32'd3, MulLat);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mult_m1x2", 3'b000, 32'hFFFF_FFFF, 32'd2, MulLat);
        push(32'h0000_0001, 32'hFFFF_FFFE);
        run_op("multu_ffx2", 3'b001, 32'hFFFF_FFFF, 32'd2, MulLat);
        push(32'h4000_0000, 32'h0000_0000);
        run_op("mult_min_sq", 3'b000, 32'h8000_0000, 32'h8000_0000, MulLat);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, DivLat);
        push(32'h0000_0001, 32'h0000_0003);
        run_op("divu_7_2", 3'b011, 32'd7, 32'd2, DivLat);
        push(32'h0000_0002, 32'hFFFF_FFF2);
        run_op("div_100_m7", 3'b010, 32'd100, 32'hFFFF_FFF9, DivLat);
        push(32'h1234_5678, 32'hFFFF_FFFF);
        run_op("div_by_zero", 3'b010, 32'h1234_5678, 32'd0, DivLat);
        push(32'h0000_0000, 32'h8000_0000);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, DivLat);
        push(m_hi, 32'h0BAD_F00D);
        run_op("mtlo", 3'b101, 32'h0BAD_F00D, 32'd0, 0);
        push(32'hAAAA_AAAA, m_lo);
        run_op("mthi", 3'b100, 32'hAAAA_AAAA, 32'd0, 0);

        // Div, ignored start at cycle 5, flush at cycle 10
        pulse_start(3'b010, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        mdOp  = 3'b000;
        din1  = 32'd9;
        din2  = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_ignored_start", busy, 1);
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_hi", hi, 32'hAAAA_AAAA);
        chk("flush_lo", lo, m_lo);
        repeat (40) @(negedge clk);
        chk("flush_busy_late", busy, 0);

        // Flush beats a same-cycle mthi
        @(posedge clk);
        #1;
        start = 1'b1;
        flush = 1'b1;
        mdOp  = 3'b100;
        din1  = 32'h5555_5555;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("flush_mthi_hi", hi, 32'hAAAA_AAAA);

        // No-op opcodes
        pulse_start(3'b110, 32'h1111_1111, 32'd1);
        pulse_start(3'b111, 32'h2222_2222, 32'd1);
        repeat (3) @(negedge clk);
        chk("noop_hi", hi, m_hi);
        chk("noop_lo", lo, m_lo);
        chk("noop_busy", busy, 0);

        // Reset mid-multiply
        pulse_start(3'b000, 32'd5, 32'd3);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", hi, '0);
        chk("midrst_lo", lo, '0);
        chk("midrst_busy", busy, 0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        push(32'h0000_0000, 32'h0000_000F);
        run_op("mult_5x3_again", 3'b000, 32'd5, 32'd3, MulLat);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
